// File: rtl/lfsr_stream_cipher_if.sv
// Valid/ready stream bundle for lfsr_stream_cipher: input beat channel plus output beat channel.
interface lfsr_stream_cipher_if #(
    parameter int unsigned DATA_W = 8
) ();
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    // slave: the cipher block; master: the surrounding source/sink
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_data);
    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_data);
endinterface

// File: rtl/lfsr_stream_cipher.sv
// XOR stream cipher keyed by a runtime-loadable Fibonacci LFSR; the keystream advances only on accepted beats.
// Define CIPHER_BYPASS_EN to add a per-beat bypass input that passes data through without consuming key.
module lfsr_stream_cipher #(
    parameter int unsigned       DATA_W = 8,
    parameter int unsigned       LFSR_W = 8,
    parameter logic [LFSR_W-1:0] TAPS   = 8'hB8,
    parameter logic [LFSR_W-1:0] SEED   = 8'hAA,
    parameter int unsigned       WARMUP = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_load,
    input  logic [LFSR_W-1:0]   cfg_seed,
    input  logic [LFSR_W-1:0]   cfg_taps,
`ifdef CIPHER_BYPASS_EN
    input  logic                bypass,
`endif
    lfsr_stream_cipher_if.slave bus,
    output logic                seed_err,
    output logic [31:0]         beat_count
);
    typedef enum logic {ST_WARMUP, ST_RUN} fsm_t;
    localparam fsm_t FSM_INIT = (WARMUP > 0) ? ST_WARMUP : ST_RUN;

    fsm_t              fsm, fsm_next;
    logic [LFSR_W-1:0] lfsr, taps, lfsr_adv;
    logic [31:0]       warm_cnt;
    logic              out_valid, in_ready, accept, byp;
    logic [DATA_W-1:0] out_data, key;

    // One advance = DATA_W single Fibonacci steps, fully unrolled.
    function automatic logic [LFSR_W-1:0] advance(input logic [LFSR_W-1:0] s,
                                                  input logic [LFSR_W-1:0] t);
        logic [LFSR_W-1:0] r;
        r = s;
        for (int unsigned i = 0; i < DATA_W; i++) r = {r[LFSR_W-2:0], ^(r & t)};
        return r;
    endfunction

`ifdef CIPHER_BYPASS_EN
    assign byp = bypass;
`else
    assign byp = 1'b0;
`endif

    assign key      = lfsr[DATA_W-1:0];
    assign lfsr_adv = advance(lfsr, taps);
    assign accept   = bus.in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) fsm <= FSM_INIT;
        else       fsm <= fsm_next;
    end

    always_comb begin
        fsm_next = fsm;
        if (cfg_load)
            fsm_next = FSM_INIT;
        else if (fsm == ST_WARMUP && warm_cnt <= 32'd1)
            fsm_next = ST_RUN;
    end

    always_comb begin
        in_ready = (fsm == ST_RUN) && !cfg_load && (!out_valid || bus.out_ready);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr       <= SEED;
            taps       <= TAPS;
            warm_cnt   <= WARMUP;
            out_valid  <= 1'b0;
            out_data   <= '0;
            seed_err   <= 1'b0;
            beat_count <= '0;
        end else begin
            // Output register runs independently of cfg_load so a pending beat survives a reload.
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= byp ? bus.in_data : (bus.in_data ^ key);
            end else if (out_valid && bus.out_ready) begin
                out_valid <= 1'b0;
            end

            if (cfg_load) begin
                lfsr       <= (cfg_seed == '0) ? SEED : cfg_seed;
                seed_err   <= (cfg_seed == '0);
                taps       <= cfg_taps;
                beat_count <= '0;
                warm_cnt   <= WARMUP;
            end else if (fsm == ST_WARMUP) begin
                lfsr     <= lfsr_adv;
                warm_cnt <= warm_cnt - 32'd1;
            end else if (accept) begin
                if (!byp) lfsr <= lfsr_adv;
                beat_count <= beat_count + 32'd1;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
endmodule

// File: tb/tb_lfsr_stream_cipher.sv
// Self-checking bench for lfsr_stream_cipher: directed vectors, encrypt/decrypt chain, warm-up and randomized traffic.
module tb_lfsr_stream_cipher;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Keystream model: the register is a sliding 8-bit window on a bit sequence whose
    // next bit is the parity of the tapped window bits.
    function automatic logic [7:0] m_adv(input logic [7:0] s, input logic [7:0] t);
        int w;
        w = int'(s);
        for (int k = 0; k < 8; k++)
            w = ((w * 2) + ($countones(w[7:0] & t) % 2)) % 256;
        return w[7:0];
    endfunction

    // ---------------- main DUT (WARMUP=0) ----------------
    logic        reset_a, cfg_load_a, seed_err_a, bypass_a, zero_b;
    logic [7:0]  cfg_seed_a, cfg_taps_a;
    logic [31:0] bc_a;
    lfsr_stream_cipher_if #(.DATA_W(8)) a_if ();

    lfsr_stream_cipher #(.DATA_W(8), .LFSR_W(8), .TAPS(8'hB8), .SEED(8'hAA), .WARMUP(0)) dut_a (
        .clk(clk), .reset(reset_a), .cfg_load(cfg_load_a),
        .cfg_seed(cfg_seed_a), .cfg_taps(cfg_taps_a),
`ifdef CIPHER_BYPASS_EN
        .bypass(bypass_a),
`endif
        .bus(a_if), .seed_err(seed_err_a), .beat_count(bc_a)
    );

    // ---------------- encrypt -> decrypt chain ----------------
    logic        reset_c, cfg_load_c, serr_e, serr_d;
    logic [31:0] bc_e, bc_d;
    lfsr_stream_cipher_if #(.DATA_W(8)) e_if ();
    lfsr_stream_cipher_if #(.DATA_W(8)) d_if ();
    assign d_if.in_valid  = e_if.out_valid;
    assign d_if.in_data   = e_if.out_data;
    assign e_if.out_ready = d_if.in_ready;

    lfsr_stream_cipher #(.DATA_W(8), .LFSR_W(8), .TAPS(8'hB8), .SEED(8'hAA), .WARMUP(0)) dut_e (
        .clk(clk), .reset(reset_c), .cfg_load(cfg_load_c), .cfg_seed(8'h00), .cfg_taps(8'h00),
`ifdef CIPHER_BYPASS_EN
        .bypass(zero_b),
`endif
        .bus(e_if), .seed_err(serr_e), .beat_count(bc_e)
    );
    lfsr_stream_cipher #(.DATA_W(8), .LFSR_W(8), .TAPS(8'hB8), .SEED(8'hAA), .WARMUP(0)) dut_d (
        .clk(clk), .reset(reset_c), .cfg_load(cfg_load_c), .cfg_seed(8'h00), .cfg_taps(8'h00),
`ifdef CIPHER_BYPASS_EN
        .bypass(zero_b),
`endif
        .bus(d_if), .seed_err(serr_d), .beat_count(bc_d)
    );

    // ---------------- warm-up instance (WARMUP=1) ----------------
    logic        reset_w, cfg_load_w, serr_w;
    logic [31:0] bc_w;
    lfsr_stream_cipher_if #(.DATA_W(8)) w_if ();

    lfsr_stream_cipher #(.DATA_W(8), .LFSR_W(8), .TAPS(8'hB8), .SEED(8'hAA), .WARMUP(1)) dut_w (
        .clk(clk), .reset(reset_w), .cfg_load(cfg_load_w), .cfg_seed(8'h00), .cfg_taps(8'h00),
`ifdef CIPHER_BYPASS_EN
        .bypass(zero_b),
`endif
        .bus(w_if), .seed_err(serr_w), .beat_count(bc_w)
    );

    // ---------------- model + per-cycle compare for dut_a ----------------
    // Checks the outputs produced by the previous edge, then predicts the next edge from current inputs.
    initial begin
        logic        m_init, exp_rdy, acc, byp_v;
        logic [7:0]  m_state, m_taps, m_od;
        logic        m_ov, m_serr;
        logic [31:0] m_bc;
        m_init = 1'b0;
        m_state = 8'hAA; m_taps = 8'hB8; m_od = 8'h00; m_ov = 1'b0; m_serr = 1'b0; m_bc = 0;
        forever begin
            @(negedge clk);
            exp_rdy = !cfg_load_a && (!m_ov || a_if.out_ready);
            if (m_init) begin
                chk("in_ready",   32'(a_if.in_ready),  32'(exp_rdy));
                chk("out_valid",  32'(a_if.out_valid), 32'(m_ov));
                chk("out_data",   32'(a_if.out_data),  32'(m_od));
                chk("beat_count", bc_a,                m_bc);
                chk("seed_err",   32'(seed_err_a),     32'(m_serr));
            end
`ifdef CIPHER_BYPASS_EN
            byp_v = bypass_a;
`else
            byp_v = 1'b0;
`endif
            if (reset_a) begin
                m_init = 1'b1;
                m_state = 8'hAA; m_taps = 8'hB8; m_od = 8'h00; m_ov = 1'b0; m_serr = 1'b0; m_bc = 0;
            end else if (m_init) begin
                acc = a_if.in_valid && exp_rdy;
                if (acc) begin
                    m_od = byp_v ? a_if.in_data : (a_if.in_data ^ m_state);
                    m_ov = 1'b1;
                end else if (m_ov && a_if.out_ready) begin
                    m_ov = 1'b0;
                end
                if (cfg_load_a) begin
                    m_state = (cfg_seed_a == 8'h00) ? 8'hAA : cfg_seed_a;
                    m_serr  = (cfg_seed_a == 8'h00);
                    m_taps  = cfg_taps_a;
                    m_bc    = 0;
                end else if (acc) begin
                    if (!byp_v) m_state = m_adv(m_state, m_taps);
                    m_bc = m_bc + 1;
                end
            end
        end
    end

    // ---------------- chain receiver ----------------
    logic [7:0] recv[$];
    initial begin
        forever begin
            @(negedge clk);
            if (reset_c) recv.delete();
            else if (d_if.out_valid && d_if.out_ready) recv.push_back(d_if.out_data);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        string msg;
        int    sent, budget, lowcnt;
        msg = "hello world !";

        reset_a = 1'b1; cfg_load_a = 1'b0; cfg_seed_a = 8'h00; cfg_taps_a = 8'h00; bypass_a = 1'b0;
        a_if.in_valid = 1'b0; a_if.in_data = 8'h00; a_if.out_ready = 1'b1;
        zero_b = 1'b0;
        reset_c = 1'b1; cfg_load_c = 1'b0; e_if.in_valid = 1'b0; e_if.in_data = 8'h00; d_if.out_ready = 1'b1;
        reset_w = 1'b1; cfg_load_w = 1'b0; w_if.in_valid = 1'b0; w_if.in_data = 8'h00; w_if.out_ready = 1'b1;

        // Reset and the 'h','e' vector
        tick(); tick();
        reset_a = 1'b0;
        chk("rst_out_valid",  32'(a_if.out_valid), 32'd0);
        chk("rst_out_data",   32'(a_if.out_data),  32'd0);
        chk("rst_beat_count", bc_a,                32'd0);
        chk("rst_seed_err",   32'(seed_err_a),     32'd0);
        chk("rst_in_ready",   32'(a_if.in_ready),  32'd1);
        chk("model_adv_aa",   32'(m_adv(8'hAA, 8'hB8)), 32'h0F9);
        a_if.in_valid = 1'b1; a_if.in_data = 8'h68;
        tick();
        chk("h_valid", 32'(a_if.out_valid), 32'd1);
        chk("h_data",  32'(a_if.out_data),  32'hC2);
        a_if.in_data = 8'h65;
        tick();
        chk("e_data",  32'(a_if.out_data),  32'h9C);
        chk("he_count", bc_a, 32'd2);
        a_if.in_valid = 1'b0;
        tick();
        chk("drain_valid", 32'(a_if.out_valid), 32'd0);

        // Back-pressure after the first beat
        reset_a = 1'b1; tick(); reset_a = 1'b0;
        a_if.out_ready = 1'b0; a_if.in_valid = 1'b1; a_if.in_data = 8'h68;
        tick();
        a_if.in_data = 8'h65;
        for (int i = 0; i < 3; i++) begin
            chk("stall_ready", 32'(a_if.in_ready), 32'd0);
            chk("stall_data",  32'(a_if.out_data), 32'hC2);
            chk("stall_count", bc_a,               32'd1);
            tick();
        end
        a_if.out_ready = 1'b1;
        #1;
        chk("release_ready", 32'(a_if.in_ready), 32'd1);
        tick();
        chk("release_data", 32'(a_if.out_data), 32'h9C);
        a_if.in_valid = 1'b0;
        tick();

        // Zero seed substitution, then a nonzero reload
        cfg_load_a = 1'b1; cfg_seed_a = 8'h00; cfg_taps_a = 8'hB8;
        a_if.in_valid = 1'b1; a_if.in_data = 8'h11;
        #1;
        chk("cfg_in_ready", 32'(a_if.in_ready), 32'd0);
        tick();
        cfg_load_a = 1'b0; a_if.in_valid = 1'b0;
        chk("cfg_no_accept", 32'(a_if.out_valid), 32'd0);
        chk("seed_err_set",  32'(seed_err_a),     32'd1);
        chk("cfg_count",     bc_a,                32'd0);
        a_if.in_valid = 1'b1; a_if.in_data = 8'h68;
        tick();
        chk("zs_h_data", 32'(a_if.out_data), 32'hC2);
        a_if.in_valid = 1'b0;
        tick();
        cfg_load_a = 1'b1; cfg_seed_a = 8'h01;
        tick();
        cfg_load_a = 1'b0;
        chk("seed_err_clr", 32'(seed_err_a), 32'd0);
        a_if.in_valid = 1'b1; a_if.in_data = 8'h00;
        tick();
        chk("seed01_data", 32'(a_if.out_data), 32'h01);
        a_if.in_valid = 1'b0;
        tick();

        // Zero taps: key decays to zero after one advance
        cfg_load_a = 1'b1; cfg_seed_a = 8'h81; cfg_taps_a = 8'h00;
        tick();
        cfg_load_a = 1'b0; a_if.in_valid = 1'b1; a_if.in_data = 8'h00;
        tick();
        chk("ztap_k0", 32'(a_if.out_data), 32'h81);
        tick();
        chk("ztap_k1", 32'(a_if.out_data), 32'h00);
        a_if.in_valid = 1'b0;
        tick();

`ifdef CIPHER_BYPASS_EN
        reset_a = 1'b1; tick(); reset_a = 1'b0;
        bypass_a = 1'b1; a_if.in_valid = 1'b1; a_if.in_data = 8'h68;
        tick();
        chk("byp_data", 32'(a_if.out_data), 32'h68);
        bypass_a = 1'b0; a_if.in_data = 8'h65;
        tick();
        chk("byp_next", 32'(a_if.out_data), 32'hCF);
        a_if.in_valid = 1'b0;
        tick();
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            a_if.in_valid  = ($urandom_range(0, 3) != 0);
            a_if.in_data   = 8'($urandom);
            a_if.out_ready = ($urandom_range(0, 3) != 0);
            bypass_a       = ($urandom_range(0, 3) == 0);
            cfg_load_a     = ($urandom_range(0, 49) == 0);
            cfg_seed_a     = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            cfg_taps_a     = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            reset_a        = ($urandom_range(0, 399) == 0);
            tick();
        end
        reset_a = 1'b0; cfg_load_a = 1'b0; a_if.in_valid = 1'b0; bypass_a = 1'b0;

        // Encrypt -> decrypt round trip with random gaps and back-pressure
        tick();
        reset_c = 1'b0;
        sent = 0; budget = 0;
        while (sent < 13 && budget < 400) begin
            e_if.in_valid   = ($urandom_range(0, 3) != 0);
            e_if.in_data    = msg[sent];
            d_if.out_ready  = ($urandom_range(0, 3) != 0);
            #1;
            if (e_if.in_valid && e_if.in_ready) sent++;
            tick();
            budget++;
        end
        e_if.in_valid = 1'b0; d_if.out_ready = 1'b1;
        budget = 0;
        while (recv.size() < 13 && budget < 100) begin
            tick();
            budget++;
        end
        chk("chain_sent",  32'(sent),        32'd13);
        chk("chain_count", 32'(recv.size()), 32'd13);
        for (int i = 0; i < 13; i++)
            if (i < recv.size()) chk("chain_byte", 32'(recv[i]), 32'(msg[i]));

        // Warm-up: in_ready low for exactly one cycle after reset
        reset_w = 1'b0;
        lowcnt = 0;
        while (!w_if.in_ready && lowcnt < 10) begin
            lowcnt++;
            tick();
        end
        chk("warm_low_cycles", 32'(lowcnt), 32'd1);
        w_if.in_valid = 1'b1; w_if.in_data = 8'h00;
        tick();
        chk("warm_data", 32'(w_if.out_data), 32'hF9);
        w_if.in_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
